// File: rtl/nnet_io_pkg.sv
// Shared types for the nnet input resource channel.
// Holds default feature geometry, the feature word type and packer states.
package nnet_io_pkg;

   localparam int FEAT_W_DEF = 18;
   localparam int N_FEAT_DEF = 10;

   typedef logic [FEAT_W_DEF-1:0] feat_t;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      PRESENT
   } state_t;

endpackage

// File: rtl/rsc_ack_edge.sv
// Consumption detector for a *_rsc_triosy_lz handshake line.
// Ports: clk, rst (async, active-high), triosy (level in), ack (0->1 pulse out).
module rsc_ack_edge (
   input  logic clk,
   input  logic rst,
   input  logic triosy,
   output logic ack
);

   logic prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= triosy;
      end
   end

   // A level that is already high is never an ack; only a fresh rise counts.
   assign ack = triosy & ~prev_q;

endmodule

// File: rtl/nnet_input_packer.sv
// Packs N_FEAT feature words into one frame and presents it on input_1_rsc_*.
// Ports: s_dat/s_vld/s_rdy word stream, flush, input_1_rsc_dat/vld/triosy_lz,
//        frame_cnt (acked frames), err (sticky ack timeout).
// Optional macro NNET_PACKER_TIMEOUT_EN enables the ack timeout and err flag.
module nnet_input_packer
   import nnet_io_pkg::*;
#(
   parameter int FEAT_W      = FEAT_W_DEF,
   parameter int N_FEAT      = N_FEAT_DEF,
   parameter int CNT_W       = 16,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [FEAT_W-1:0]        s_dat,
   input  logic                     s_vld,
   output logic                     s_rdy,
   input  logic                     flush,
   output logic [N_FEAT*FEAT_W-1:0] input_1_rsc_dat,
   output logic                     input_1_rsc_vld,
   input  logic                     input_1_rsc_triosy_lz,
   output logic [CNT_W-1:0]         frame_cnt,
   output logic                     err
);

   localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N_FEAT - 1);

   if (N_FEAT < 2 || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("nnet_input_packer: N_FEAT must be >= 2, TIMEOUT_CYC >= 1");
   end

   state_t state_q;
   state_t state_d;

   logic [IDX_W-1:0] idx_q;

   // The last word goes straight to the output, so only N_FEAT-1 slots.
   logic [N_FEAT-2:0][FEAT_W-1:0] slot_q;

   logic ack;
   logic accept;
   logic go_present;
   logic take_ack;
   logic restart;
   logic tmo_now;
   logic tmo_hit;

   rsc_ack_edge u_ack (
      .clk    (clk),
      .rst    (rst),
      .triosy (input_1_rsc_triosy_lz),
      .ack    (ack)
   );

   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      go_present = 1'b0;
      take_ack   = 1'b0;
      restart    = 1'b0;
      tmo_hit    = 1'b0;
      unique case (state_q)
         IDLE: begin
            state_d = FILL;
         end
         FILL: begin
            if (flush) begin
               restart = 1'b1;
            end else if (s_vld && s_rdy) begin
               accept = 1'b1;
               if (idx_q == LAST) begin
                  go_present = 1'b1;
                  state_d    = PRESENT;
               end
            end
         end
         PRESENT: begin
            // flush beats ack so a flushed frame is never counted
            if (flush) begin
               restart = 1'b1;
               state_d = FILL;
            end else if (ack) begin
               take_ack = 1'b1;
               state_d  = FILL;
            end else if (tmo_now) begin
               tmo_hit = 1'b1;
               state_d = FILL;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q           <= '0;
         slot_q          <= '0;
         s_rdy           <= 1'b0;
         input_1_rsc_vld <= 1'b0;
         input_1_rsc_dat <= '0;
         frame_cnt       <= '0;
      end else begin
         s_rdy           <= (state_d == FILL);
         input_1_rsc_vld <= (state_d == PRESENT);

         if (restart || take_ack || tmo_hit) begin
            idx_q <= '0;
         end else if (accept) begin
            idx_q <= go_present ? '0 : idx_q + 1'b1;
         end

         if (accept && !go_present) begin
            slot_q[idx_q] <= s_dat;
         end

         // Output only changes when a complete frame lands.
         if (go_present) begin
            input_1_rsc_dat <= {s_dat, slot_q};
         end

         if (take_ack) begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

`ifdef NNET_PACKER_TIMEOUT_EN

   localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   logic [TMO_W-1:0] tmo_q;
   logic             err_q;

   // Counter sits at zero outside PRESENT, so entry always starts fresh.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (state_q == PRESENT && state_d == PRESENT) begin
            tmo_q <= tmo_q + 1'b1;
         end else begin
            tmo_q <= '0;
         end
         if (tmo_hit) begin
            err_q <= 1'b1;
         end
      end
   end

   assign tmo_now = (state_q == PRESENT) && (tmo_q == TMO_LAST);
   assign err     = err_q;

`else

   assign tmo_now = 1'b0;
   assign err     = 1'b0;

`endif

endmodule
